e_mem_rd_ctrl: RTL

//  Read-side controller for the BRAM sample buffer filled by the write-address generator.

---
 rtl/e_mem_rd_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/e_mem_rd_ctrl.sv
// e_mem_rd_ctrl: read-side controller for the BRAM sample buffer.
// Replays the writer's address walk (linear 0..WRAP_HI, then circular over
// WRAP_LO..WRAP_HI). It reads only words the writer has committed and streams
// them out on a valid/ready port. A 4-entry credit FIFO absorbs BRAM read latency.
//
// Ports:
//   CLK          clock
//   rst_n        synchronous reset, active low
//   wr_adv       writer committed one word this cycle
//   rd_start     pulse: IDLE -> RUN
//   rd_stop      pulse: stop issuing reads and drain
//   mem_rd_en    BRAM read enable (combinational from registered state)
//   mem_rd_addr  BRAM read address (combinational from registered state)
//   mem_rd_data  BRAM read data, valid RD_LAT cycles after mem_rd_en
//   m_data       stream data (FIFO head)
//   m_valid      stream valid
//   m_ready      stream ready
//   avail        words written but not yet issued
//   busy         controller not idle
//   ovf_err      sticky: writer overran reader
`timescale 1ns/1ps
module e_mem_rd_ctrl #(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned WRAP_HI   = 262143,
  parameter int unsigned WRAP_LO   = 259072,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_AVAIL = 3072
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              wr_adv,
  input  logic              rd_start,
  input  logic              rd_stop,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W:0]   avail,
  output logic              busy,
  output logic              ovf_err
);

  localparam int unsigned AVAIL_W    = ADDR_W + 1;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FPTR_W     = 2;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned CRED_W     = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_ptr_q;
  logic [RD_LAT-1:0]   vld_sr_q;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [FPTR_W-1:0]   fifo_wp_q, fifo_rp_q;
  logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [AVAIL_W-1:0]  avail_d;
  logic                ovf_d;
  logic [CRED_W-1:0]   credit_used_c;
  logic                issue_c;
  logic                capture_c;
  logic                pop_c;

  // Credits: FIFO occupancy plus reads still in the BRAM pipeline never exceed FIFO depth.
  assign credit_used_c = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
  assign issue_c       = (state_q == ST_RUN) && (avail != '0) &&
                         (credit_used_c < CRED_W'(FIFO_DEPTH));
  assign capture_c     = vld_sr_q[RD_LAT-1];
  assign pop_c         = m_valid && m_ready;

  assign mem_rd_en   = issue_c;
  assign mem_rd_addr = rd_ptr_q;
  assign m_data      = fifo_mem_q[fifo_rp_q];

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != ST_IDLE);
    end
  end

  // FSM next state; simultaneous start+stop in IDLE is treated as no start
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (rd_start && !rd_stop) state_d = ST_RUN;
      ST_RUN:   if (rd_stop) state_d = ST_DRAIN;
      ST_DRAIN: if ((inflight_q == '0) && (fifo_cnt_q == '0)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of avail / overrun flag / in-flight and FIFO counts
  always_comb begin
    avail_d    = avail;
    ovf_d      = ovf_err;
    inflight_d = inflight_q;
    fifo_cnt_d = fifo_cnt_q;

    if (wr_adv && !issue_c) begin
      if (avail == AVAIL_W'(MAX_AVAIL)) ovf_d = 1'b1;
      else                              avail_d = avail + AVAIL_W'(1);
    end else if (!wr_adv && issue_c) begin
      avail_d = avail - AVAIL_W'(1);
    end

    case ({issue_c, capture_c})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase

    case ({capture_c, pop_c})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Read pointer, counters and return FIFO
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      avail      <= '0;
      ovf_err    <= 1'b0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      fifo_wp_q  <= '0;
      fifo_rp_q  <= '0;
      m_valid    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
    end else begin
      avail      <= avail_d;
      ovf_err    <= ovf_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      m_valid    <= (fifo_cnt_d != '0);
      if (issue_c) begin
        rd_ptr_q <= (rd_ptr_q == ADDR_W'(WRAP_HI)) ? ADDR_W'(WRAP_LO)
                                                   : rd_ptr_q + ADDR_W'(1);
      end
      if (capture_c) begin
        fifo_mem_q[fifo_wp_q] <= mem_rd_data;
        fifo_wp_q             <= fifo_wp_q + FPTR_W'(1);
      end
      if (pop_c) fifo_rp_q <= fifo_rp_q + FPTR_W'(1);
    end
  end

  // Return-valid pipeline; clearing it on reset drops any late BRAM data
  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge CLK) begin
        if (!rst_n) vld_sr_q <= '0;
        else        vld_sr_q <= issue_c;
      end
    end else begin : g_latn
      always_ff @(posedge CLK) begin
        if (!rst_n) vld_sr_q <= '0;
        else        vld_sr_q <= {vld_sr_q[RD_LAT-2:0], issue_c};
      end
    end
  endgenerate

  a_no_fifo_overflow: assert property (@(posedge CLK) disable iff (!rst_n)
    !(capture_c && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));

endmodule
